// File: rtl/data_mem_responder.sv
// Memory-side responder for the core load/store port: one outstanding request,
// fixed-latency byte/half/word access to an internal word RAM, registered response.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT     = 2'd1;
    localparam logic [1:0] RESP     = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        write_p0;
    logic [2:0]  funct3_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          access_now;
    logic          err_now;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;

    function automatic logic access_err(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] addr);
        logic bad_f3;
        logic misal;
        logic oob;
        bad_f3 = wr ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'b011 || f3[2:1] == 2'b11);
        misal  = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        oob    = {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS);
        return bad_f3 || misal || oob;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] data;
        logic [31:0] mask;
        data = wd << {lane, 3'b000};
        case (f3[1:0])
            2'b00:   mask = 32'h0000_00FF << {lane, 3'b000};
            2'b01:   mask = 32'h0000_FFFF << {lane, 3'b000};
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    assign accept     = (state == IDLE) && req_valid && req_ready;
    assign access_now = (state == WAIT) && (cnt == 4'd0);
    assign err_now    = access_err(write_p0, funct3_p0, addr_p0);
    assign word_idx   = addr_p0[AW+1:2];
    assign rd_word    = mem[word_idx];

    // p0: request captured at the accept edge
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0  <= req_write;
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr;
            wdata_p0  <= req_wdata;
        end
    end

    // p1: RAM access when the latency counter expires; reset abandons an uncommitted store
    always_ff @(posedge clk) begin
        if (!reset && access_now && write_p0 && !err_now) begin
            mem[word_idx] <= store_merge(funct3_p0, addr_p0[1:0], rd_word, wdata_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= WAIT;
                        req_ready <= 1'b0;
                        cnt       <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err_now;
                        resp_rdata <= (err_now || write_p0) ? 32'd0
                                      : load_extract(funct3_p0, addr_p0[1:0], rd_word);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: handshakes, byte/half/word access,
// error cases, response backpressure and reset during a pending store.
module tb_data_mem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request with resp_ready=1 and returns the response and its latency (-1 = none).
    task automatic transact(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er,
                            output int lat, output logic after);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
        after = resp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", resp_err); end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; logic after;
        transact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, after);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL sw_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, er); end
        checks++; if (after !== 1'b0) begin errors++; $display("FAIL sw_pulse got=%b exp=0", after); end
        transact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, after);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL lw_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got=%b exp=0", er); end
        checks++; if (after !== 1'b0) begin errors++; $display("FAIL lw_pulse got=%b exp=0", after); end
    endtask

    task automatic test_byte_half();
        logic        v_wr [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  v_f3 [9] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b101, 3'b001, 3'b010, 3'b001, 3'b010};
        logic [31:0] v_a  [9] = '{32'h13, 32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h14, 32'h16, 32'h14};
        logic [31:0] v_wd [9] = '{32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFABCD, 32'h0};
        logic [31:0] v_ex [9] = '{32'h0, 32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF, 32'h000080AD,
                                  32'hFFFF80AD, 32'h0, 32'h0, 32'hABCD0000};
        logic [31:0] rd; logic er; int lat; logic after;
        for (int i = 0; i < 9; i++) begin
            transact(v_wr[i], v_f3[i], v_a[i], v_wd[i], rd, er, lat, after);
            checks++;
            if (rd !== v_ex[i] || er !== 1'b0 || lat !== LAT) begin
                errors++;
                $display("FAIL subword_%0d got=%h err=%b lat=%0d exp=%h err=0 lat=%0d", i, rd, er, lat, v_ex[i], LAT);
            end
        end
    endtask

    task automatic test_errors();
        logic        v_wr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  v_f3 [6] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b010};
        logic [31:0] v_a  [6] = '{32'h11, 32'h10, 32'h12, 32'h10, 32'h10, 32'h10};
        logic [31:0] v_wd [6] = '{32'h1234, 32'h0, 32'h0, 32'h55555555, 32'h0, 32'h0};
        logic        v_er [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] v_ex [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80ADBEEF};
        logic [31:0] rd; logic er; int lat; logic after;
        for (int i = 0; i < 6; i++) begin
            transact(v_wr[i], v_f3[i], v_a[i], v_wd[i], rd, er, lat, after);
            checks++;
            if (rd !== v_ex[i] || er !== v_er[i] || lat !== LAT) begin
                errors++;
                $display("FAIL error_%0d got=%h err=%b lat=%0d exp=%h err=%b lat=%0d", i, rd, er, lat, v_ex[i], v_er[i], LAT);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int n;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_addr = 32'h14;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h80ADBEEF || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d valid=%b rdata=%h req_ready=%b exp 1/80adbeef/0", i, resp_valid, resp_rdata, req_ready);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake valid=%b req_ready=%b exp 0/1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL second_accept req_ready=%b exp=0", req_ready); end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== LAT || resp_rdata !== 32'hABCD0000) begin
            errors++;
            $display("FAIL second_resp lat=%0d rdata=%h exp lat=%0d rdata=abcd0000", lat, resp_rdata, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        logic        v_wr [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] v_a  [5] = '{32'h0, 32'hFFC, 32'h1000, 32'h1000, 32'h0};
        logic [31:0] v_wd [5] = '{32'h0, 32'h5A5A5A5A, 32'h77777777, 32'h0, 32'h0};
        logic        v_er [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] rd; logic er; int lat; logic after;
        for (int i = 0; i < 5; i++) begin
            transact(v_wr[i], 3'b010, v_a[i], v_wd[i], rd, er, lat, after);
            checks++;
            if (rd !== 32'h0 || er !== v_er[i]) begin
                errors++;
                $display("FAIL range_%0d got=%h err=%b exp=00000000 err=%b", i, rd, er, v_er[i]);
            end
        end
        transact(1'b0, 3'b010, 32'hFFC, 32'h0, rd, er, lat, after);
        checks++; if (rd !== 32'h5A5A5A5A || er !== 1'b0) begin errors++; $display("FAIL last_word got=%h err=%b exp=5a5a5a5a err=0", rd, er); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; logic after;
        transact(1'b1, 3'b010, 32'h20, 32'h0, rd, er, lat, after);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h11111111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset valid=%b req_ready=%b exp 0/1", resp_valid, req_ready);
        end
        for (int i = 0; i < LAT + 1; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_stale valid=%b exp=0", resp_valid); end
        transact(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, after);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL mid_reset_ram got=%h err=%b exp=00000000 err=0", rd, er); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        #1;
        test_reset();
        test_store_load();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
